key_addr_input: RTL
===================

KEY_ADDR_INPUT -- requirements
Module: key_addr_input

Interface
REQ-001 Parameter DB_CNT, default 250_000, is the number of consecutive clk cycles a synchronized button level must hold before it is accepted (minimum 2).
REQ-002 Parameter RPT_CNT, default 12_500_000, is the auto-repeat interval in clk cycles while INC or DEC is held (minimum 2; 0 disables repeat).
REQ-003 Parameter ADDR_W, default 10, is the address width.
REQ-004 clk  input  1  the single clock; every flop is clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 btn_inc  input  1  raw, asynchronous, bouncing increment button; active-high.
REQ-007 btn_dec  input  1  raw, asynchronous, bouncing decrement button; active-high.
REQ-008 btn_go  input  1  raw, asynchronous, bouncing resume button; active-high.
REQ-009 en  input  1  address-browse mode enable, synchronous to clk.
REQ-010 addr  output  ADDR_W  memory address for the CPU debug read port.
REQ-011 go_pulse  output  1  single-cycle resume strobe to the CPU.
REQ-012 inc_pulse / dec_pulse  output  1 each  single-cycle accepted-step strobes.
REQ-013 held  output  3  debounced stable levels {go, dec, inc}.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-015 Each button SHALL have its own debounce counter.
- The counter increments while the synchronized level differs from the stable level.
- The counter clears on any cycle where the two levels match.
- The stable level toggles, and the counter clears, on the edge where the count would reach DB_CNT.
REQ-016 Each button SHALL have a FSM with states IDLE, PRESSED, REPEAT.
- IDLE -> PRESSED on the stable rise; the strobe fires for exactly 1 cycle.
- PRESSED -> REPEAT after the stable level has stayed high for RPT_CNT cycles; the strobe fires for 1 cycle.
- In REPEAT, the strobe fires once every RPT_CNT cycles.
- Any state -> IDLE on the stable fall, with no strobe.
REQ-017 btn_go SHALL never auto-repeat: one press gives exactly one go_pulse.
REQ-018 Latency: when a raw input is steady from edge t, the strobe SHALL be high during the cycle after edge t+2+DB_CNT.
REQ-019 A bounce that is shorter than DB_CNT cycles SHALL produce no strobe and no change to held.
REQ-020 Address update rules:
- en=0: addr SHALL be 0 on the next edge, and strobes SHALL be ignored for addr.
- en=1 with inc_pulse only: addr+1, modulo 2^ADDR_W.
- en=1 with dec_pulse only: addr-1, modulo 2^ADDR_W.
- en=1 with both strobes in the same cycle: addr unchanged.
REQ-021 Wrap-around: 2^ADDR_W-1 +1 SHALL give 0, and 0 -1 SHALL give 2^ADDR_W-1, with no saturation.
REQ-022 A falling en SHALL clear addr even if a strobe is active in the same cycle; a rising en SHALL start browsing from 0.
REQ-023 inc_pulse, dec_pulse and go_pulse SHALL be generated independently of en.
REQ-024 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-025 When rst is low, the following SHALL be asynchronously forced and held until the first edge after rst is released:
- addr=0, go_pulse=0, inc_pulse=0, dec_pulse=0, held=0;
- all synchronizers, debounce counters and repeat counters = 0;
- all FSMs = IDLE.
REQ-026 If rst asserts while a button is held, no strobe SHALL occur at release of reset until that button has been stable high for DB_CNT cycles after release.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard the partial count.

Verification (DB_CNT=4, RPT_CNT=8, ADDR_W=4)
REQ-028 en=1, btn_inc steady high from edge 0 -> inc_pulse high only in the cycle after edge 6, and addr=1 after edge 7.
REQ-029 btn_inc held 40 cycles -> a strobe after edge 6, then one strobe every 8 cycles: 5 strobes total, addr=5.
REQ-030 btn_dec toggles 1 cycle high / 1 cycle low for 30 cycles -> no dec_pulse, held[1]=0, addr unchanged.
REQ-031 addr=15 then one inc press -> addr=0; then one dec press -> addr=15.
REQ-032 addr=3, en drops in the same cycle as an inc_pulse -> addr=0 next edge; btn_go held 100 cycles -> exactly one go_pulse.
REQ-033 rst pulled low mid-debounce with btn_inc still high -> all outputs 0 immediately, and the first inc_pulse appears DB_CNT+2 cycles after rst rises.

Source files
------------

// File: rtl/key_addr_input_if.sv
// Button inputs, browse enable and address/strobe outputs of the debug address selector.
interface key_addr_input_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              btn_inc;
  logic              btn_dec;
  logic              btn_go;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              go_pulse;
  logic              inc_pulse;
  logic              dec_pulse;
  logic [2:0]        held;

  modport master (
    output btn_inc, btn_dec, btn_go, en,
    input  addr, go_pulse, inc_pulse, dec_pulse, held
  );

  modport slave (
    input  btn_inc, btn_dec, btn_go, en,
    output addr, go_pulse, inc_pulse, dec_pulse, held
  );
endinterface

// File: rtl/key_addr_input.sv
// Debounced push-button front end: synchronizes, debounces and auto-repeats three buttons,
// and steps a browse address for the CPU debug read port.
module key_addr_input #(
  parameter int unsigned DB_CNT  = 250_000,
  parameter int unsigned RPT_CNT = 12_500_000,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  key_addr_input_if.slave  bus
);

  localparam int unsigned N_BTN    = 3;
  localparam int unsigned DB_W     = (DB_CNT < 2) ? 1 : $clog2(DB_CNT);
  localparam int unsigned DB_LAST  = (DB_CNT < 2) ? 0 : DB_CNT - 1;
  localparam int unsigned RPT_W    = (RPT_CNT < 2) ? 1 : $clog2(RPT_CNT);
  localparam int unsigned RPT_LAST = (RPT_CNT < 2) ? 0 : RPT_CNT - 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] REPEAT  = 2'd2;

  logic [N_BTN-1:0]  raw;
  logic [N_BTN-1:0]  stable;
  logic [N_BTN-1:0]  pulse;
  logic [ADDR_W-1:0] addr_q;

  // bit order {go, dec, inc}
  assign raw = {bus.btn_go, bus.btn_dec, bus.btn_inc};

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    // go (index 2) is a one-shot; inc/dec repeat unless RPT_CNT disables it
    localparam bit RPT_EN = (i != 2) && (RPT_CNT >= 2);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_nxt;
    logic [DB_W-1:0]  db_q;
    logic [DB_W-1:0]  db_nxt;
    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_nxt;
    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic             pulse_q;
    logic             pulse_nxt;
    logic             rise;
    logic             fall;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= raw[i];
        sync2_q <= sync1_q;
      end
    end

    // stable flips on the edge the mismatch count would reach DB_CNT
    always_comb begin
      stable_nxt = stable_q;
      db_nxt     = '0;
      if (sync2_q != stable_q) begin
        if (db_q == DB_W'(DB_LAST)) begin
          stable_nxt = ~stable_q;
        end else begin
          db_nxt = db_q + DB_W'(1);
        end
      end
    end

    assign rise = ~stable_q & stable_nxt;
    assign fall = stable_q & ~stable_nxt;

    always_comb begin
      state_nxt = state_q;
      rpt_nxt   = '0;
      pulse_nxt = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_nxt = PRESSED;
            pulse_nxt = 1'b1;
          end
        end
        PRESSED, REPEAT: begin
          if (fall) begin
            state_nxt = IDLE;
          end else if (RPT_EN) begin
            if (rpt_q == RPT_W'(RPT_LAST)) begin
              state_nxt = REPEAT;
              pulse_nxt = 1'b1;
            end else begin
              rpt_nxt = rpt_q + RPT_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stable_q <= 1'b0;
        db_q     <= '0;
        rpt_q    <= '0;
        state_q  <= IDLE;
        pulse_q  <= 1'b0;
      end else begin
        stable_q <= stable_nxt;
        db_q     <= db_nxt;
        rpt_q    <= rpt_nxt;
        state_q  <= state_nxt;
        pulse_q  <= pulse_nxt;
      end
    end

    assign stable[i] = stable_q;
    assign pulse[i]  = pulse_q;
  end

  // simultaneous inc and dec cancel; leaving browse mode always clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else if (!bus.en) begin
      addr_q <= '0;
    end else if (pulse[0] && !pulse[1]) begin
      addr_q <= addr_q + ADDR_W'(1);
    end else if (pulse[1] && !pulse[0]) begin
      addr_q <= addr_q - ADDR_W'(1);
    end
  end

  assign bus.addr      = addr_q;
  assign bus.inc_pulse = pulse[0];
  assign bus.dec_pulse = pulse[1];
  assign bus.go_pulse  = pulse[2];
  assign bus.held      = stable;

endmodule
